quad_enc_mc: RTL



---
 rtl/quad_enc_mc.sv | 115 +++++++++++
 1 files changed

// File: rtl/quad_enc_mc.sv
// quad_enc_mc: multi-channel debounced quadrature decoder with step pulses and position counters
// Ports: clk; rst_n async active-low; key_a/key_b raw encoder pins; clr per-channel clear of pos/err;
//        l_pulse/r_pulse one-cycle step pulses; pos packed signed counters (CNT_W each); err sticky illegal-jump flag
module quad_enc_mc #(
    parameter int CH        = 2,
    parameter int CLK_HZ    = 12_000_000,
    parameter int SAMPLE_US = 250,
    parameter int DEB_N     = 3,
    parameter int CNT_W     = 16,
    parameter int MODE      = 2,
    parameter int WRAP      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         key_a,
    input  logic [CH-1:0]         key_b,
    input  logic [CH-1:0]         clr,
    output logic [CH-1:0]         l_pulse,
    output logic [CH-1:0]         r_pulse,
    output logic [CH*CNT_W-1:0]   pos,
    output logic [CH-1:0]         err
);
    localparam int DIV = CLK_HZ / 1_000_000 * SAMPLE_US;
    localparam int DW  = $clog2(DIV);
    localparam logic [CNT_W-1:0] P_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] P_MIN = {1'b1, {(CNT_W-1){1'b0}}};
    typedef enum logic {INIT, RUN} state_t;
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    always_comb begin
        tick  = div_q == DW'(DIV - 1);
        div_d = tick ? '0 : div_q + DW'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end
    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [1:0]       s1_q, s2_q, cand_q, cand_d, filt_q, filt_d, stable, chg;
        logic [1:0][3:0]  run_q, run_d;
        logic [CNT_W-1:0] pos_q, pos_d;
        logic             l_q, l_d, r_q, r_d, err_q, err_d, legal, par, r4;
        // pin bit 1 is A, bit 0 is B throughout
        always_comb begin
            state_d = state_q;
            cand_d  = cand_q;
            run_d   = run_q;
            filt_d  = filt_q;
            stable  = 2'b00;
            if (tick) begin
                for (int p = 0; p < 2; p++) begin
                    cand_d[p] = s2_q[p];
                    run_d[p]  = s2_q[p] != cand_q[p] ? 4'd1 : run_q[p] == 4'd15 ? run_q[p] : run_q[p] + 4'd1;
                    stable[p] = run_d[p] >= 4'(DEB_N);
                end
                // INIT adopts the settled pin state silently once both pins are stable
                if (state_q == INIT) begin
                    if (&stable) begin
                        filt_d  = cand_d;
                        state_d = RUN;
                    end
                end else begin
                    for (int p = 0; p < 2; p++)
                        if (stable[p]) filt_d[p] = cand_d[p];
                end
            end
            chg   = state_q == RUN ? filt_d ^ filt_q : 2'b00;
            legal = chg == 2'b10 || chg == 2'b01;
            par   = filt_d[1] ^ filt_d[0];
            // right when A moves to A!=B or B moves to A==B
            r4    = legal && (chg[1] ? par : !par);
            r_d   = MODE == 1 ? legal && filt_q == 2'b00 && filt_d == 2'b10
                  : MODE == 2 ? legal && chg[1] && par : r4;
            l_d   = MODE == 1 ? legal && filt_q == 2'b01 && filt_d == 2'b11
                  : MODE == 2 ? legal && chg[1] && !par : legal && !r4;
            pos_d = r_d && (WRAP != 0 || pos_q != P_MAX) ? pos_q + CNT_W'(1)
                  : l_d && (WRAP != 0 || pos_q != P_MIN) ? pos_q - CNT_W'(1) : pos_q;
            err_d = err_q || chg == 2'b11;
            if (clr[i]) begin
                pos_d = '0;
                err_d = 1'b0;
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= INIT;
                s1_q    <= '0;
                s2_q    <= '0;
                cand_q  <= '0;
                run_q   <= '0;
                filt_q  <= '0;
                pos_q   <= '0;
                l_q     <= 1'b0;
                r_q     <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                s1_q    <= {key_a[i], key_b[i]};
                s2_q    <= s1_q;
                cand_q  <= cand_d;
                run_q   <= run_d;
                filt_q  <= filt_d;
                pos_q   <= pos_d;
                l_q     <= l_d;
                r_q     <= r_d;
                err_q   <= err_d;
            end
        end
        assign l_pulse[i]               = l_q;
        assign r_pulse[i]               = r_q;
        assign err[i]                   = err_q;
        assign pos[i*CNT_W +: CNT_W]    = pos_q;
    end
endmodule
